online_ccm_pipe: RTL and testbench
==================================

Name: online_ccm_pipe

Overview:
- Pipelined, parametrised successor of the fixed ×44 online constant-coefficient multiplier (CCM).
- Computes y = C·x, where C = Σ (±2^S_i) over up to three shifted terms, in redundant signed-digit (SD) form.
- Chains two existing online_adder instances, with registered stages between them and a valid/ready handshake, so it can sit in an overclocked datapath with backpressure.

Parameters:
- Stage, 4, input digit count; x is 2*Stage bits.
- S0, 5, shift of term 0. Must be the largest shift (SMAX = S0).
- S1, 3, shift of term 1 (S1 ≤ S0).
- S2, 2, shift of term 2 (S2 ≤ S0).
- NEG0 / NEG1 / NEG2, 0, 1 = subtract that term.
- EN2, 1, 0 = two-term CCM; term 2 is forced to zero.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: asynchronous, active-low.
- in_valid, in, 1, x is valid.
- in_ready, out, 1, block accepts x this cycle.
- x, in, 2*Stage, SD operand.
- out_valid, out, 1, y is valid.
- out_ready, in, 1, downstream accepts y.
- y, out, 2*(Stage+S0+2), SD product.
- busy, out, 1, any stage holds valid data.

Behaviour:
- SD encoding:
  - Digit k occupies bits [2k+1:2k]; value = bit[2k+1] − bit[2k]; weight 2^k.
  - Pattern 11 is legal and equals 0.
  - value(y) must equal C·value(x) exactly. The bit pattern itself is not checked, since the encoding is redundant.
- Term alignment:
  - t_i = x shifted up S_i digits, zero-filled below and above, giving Stage+S0 digits.
  - Negation swaps the p/n bits of every digit; no adder is needed.
  - If EN2=0, t2 = 0.
- Datapath:
  - R0 captures x.
  - R1 = online_adder(Stage+S0 digits) of t0(R0) + t1(R0), cin=0; result is Stage+S0+1 digits.
  - R2 = online_adder(Stage+S0+1 digits) of R1 + t2 zero-extended by one digit, cin=0; result is Stage+S0+2 digits; y = R2.
  - The t_i for stage 2 come from a copy of R0 carried alongside R1 (x1 register).
- Latency: 3 cycles from accept to out_valid when out_ready is held high. Throughput: 1 result per cycle.
- Handshake:
  - Each stage k has a valid bit v_k.
  - Stage k loads when !v_k or stage k+1 loads. Stage 2 "loads" when out_ready is high.
  - in_ready = !v0 or stage 1 loads.
  - out_valid = v2.
  - Transfer occurs on valid && ready. Data and valid bits hold while stalled.
  - in_ready is combinational from out_ready, with no register skid.
  - Results leave strictly in input order; nothing is dropped or duplicated.
- Capacity: 3 in-flight results. With out_ready low, at most 3 accepts occur, then in_ready = 0.
- Simultaneous events:
  - Accept and emit in the same cycle while full is allowed, so a full pipeline keeps full throughput.
  - If in_valid=0, a bubble propagates (v0 clears when stage 1 loads).
- busy = v0 | v1 | v2.
- Reset (rst_n low, at any time including mid-stall):
  - v0 = v1 = v2 = 0; out_valid = 0; busy = 0; y = 0; data registers = 0.
  - in_ready = 1 while in reset and on the first cycle after it.
  - In-flight data is discarded.
- Width guarantee: |C·x| ≤ (2^S0+2^S1+2^S2)(2^Stage − 1) < 2^(Stage+S0+2), so no overflow is possible for any legal x.
- Elaboration error if S1 > S0 or S2 > S0.

Test Plan:
- Default C=44, Stage=4, x=8'b10101010 (+15) -> after 3 cycles out_valid=1, value(y)=660. Also x=8'b01010101 (−15) -> −660.
- x digits MSD→LSD (+1, 0, −1, +1) = 8'b10000110 (+7) -> value(y)=308. x=8'b11111111 (0) -> value(y)=0.
- NEG1=1 (C=28), x=+15 -> 420. EN2=0 (C=40), x=+15 -> 600.
- Back-to-back x=1, 2, 3, 4, 5 with out_ready=1 -> five consecutive out_valid cycles with values 44, 88, 132, 176, 220, in order.
- out_ready=0 for 6 cycles while in_valid=1 with x=1..5 -> exactly 3 accepts, in_ready=0, busy=1. After out_ready=1: outputs 44, 88, 132, 176, 220 in order, no loss or duplication.
- rst_n pulsed low mid-stall (pipeline full) -> out_valid=0 and busy=0 immediately (async). After release, a new x=+2 yields 88 after 3 cycles; no stale result ever appears.

Source files
------------

// File: rtl/online_ccm_pipe.sv
// online_ccm_pipe -- pipelined online constant-coefficient multiplier.
//
// y = C * x with C = (+/-)2^S0 (+/-) 2^S1 [(+/-) 2^S2], all operands in
// redundant signed-digit form (digit k = bits [2k+1:2k], value p - n).
// Three registered stages with a valid/ready handshake:
//   R0 holds x, R1 = t0 + t1, R2 = R1 + t2 (= y).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  operand handshake, x = 2*Stage-bit SD operand
//   out_valid/ready result handshake,  y = 2*(Stage+S0+2)-bit SD product
//   busy            any stage holds valid data

// Carry-free radix-2 SD adder (two full-adder layers, PPM then MMP).
// Result has one more digit than the operands; cin is a +1 at digit 0.
module online_adder #(
  parameter int N = 4
) (
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  input  logic           cin,
  output logic [2*N+1:0] s
);
  logic [N:0]   h;   // positive transfer out of layer 1
  logic [N-1:0] u;   // negative interim digit of layer 1
  logic [N:0]   zp;  // positive digit of layer 2
  logic [N:0]   zn;  // negative transfer out of layer 2

  always_comb begin
    h  = '0;
    u  = '0;
    zp = '0;
    zn = '0;
    h[0] = cin;
    // Layer 1: a_p + b_p - a_n = 2*h[k+1] - u[k] (negative input inverted).
    for (int k = 0; k < N; k++) begin
      h[k+1] = (a[2*k+1] & b[2*k+1]) | (a[2*k+1] & ~a[2*k]) | (b[2*k+1] & ~a[2*k]);
      u[k]   = ~(a[2*k+1] ^ b[2*k+1] ^ ~a[2*k]);
    end
    // Layer 2: h[k] - u[k] - b_n = zp[k] - 2*zn[k+1] (positive input inverted).
    for (int k = 0; k < N; k++) begin
      zn[k+1] = (~h[k] & u[k]) | (~h[k] & b[2*k]) | (u[k] & b[2*k]);
      zp[k]   = ~(~h[k] ^ u[k] ^ b[2*k]);
    end
    zp[N] = h[N];
    for (int k = 0; k <= N; k++) begin
      s[2*k+1] = zp[k];
      s[2*k]   = zn[k];
    end
  end
endmodule

module online_ccm_pipe #(
  parameter int Stage = 4,
  parameter int S0    = 5,
  parameter int S1    = 3,
  parameter int S2    = 2,
  parameter bit NEG0  = 1'b0,
  parameter bit NEG1  = 1'b0,
  parameter bit NEG2  = 1'b0,
  parameter bit EN2   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*Stage-1:0]        x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*(Stage+S0+2)-1:0] y,
  output logic                      busy
);
  localparam int XW  = 2*Stage;
  localparam int TN  = Stage + S0;   // digits of an aligned term
  localparam int TW  = 2*TN;
  localparam int R1W = 2*(TN+1);
  localparam int YW  = 2*(TN+2);

  if (S1 > S0 || S2 > S0) begin : g_bad_shift
    $error("online_ccm_pipe: S0 must be the largest shift");
  end

  // Shift x up by sh digits into a TN-digit term; negation swaps p/n.
  function automatic logic [TW-1:0] align(input logic [XW-1:0] xv, input int sh,
                                          input bit neg);
    logic [TW-1:0] t;
    t = TW'(xv) << (2*sh);
    if (neg) begin
      for (int k = 0; k < TN; k++) t[2*k +: 2] = {t[2*k], t[2*k+1]};
    end
    return t;
  endfunction

  logic [2:0]     vld_pipe_q, vld_pipe_d;
  logic [XW-1:0]  x0_q, x0_d, x1_q, x1_d;
  logic [R1W-1:0] r1_q, r1_d;
  logic [YW-1:0]  r2_q, r2_d;
  logic           ld0, ld1, ld2;
  logic [TW-1:0]  t0, t1, t2;
  logic [R1W-1:0] sum1, t2e;
  logic [YW-1:0]  sum2;

  // Backpressure chain: a stage may load when empty or when its successor loads.
  always_comb begin
    ld2 = ~vld_pipe_q[2] | out_ready;
    ld1 = ~vld_pipe_q[1] | ld2;
    ld0 = ~vld_pipe_q[0] | ld1;
  end

  always_comb begin
    t0  = align(x0_q, S0, NEG0);
    t1  = align(x0_q, S1, NEG1);
    t2  = EN2 ? align(x1_q, S2, NEG2) : '0;
    t2e = {2'b00, t2};
  end

  online_adder #(.N(TN))   u_add1 (.a(t0),   .b(t1),  .cin(1'b0), .s(sum1));
  online_adder #(.N(TN+1)) u_add2 (.a(r1_q), .b(t2e), .cin(1'b0), .s(sum2));

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    if (ld0) begin
      vld_pipe_d[0] = in_valid;
      if (in_valid) x0_d = x;
    end
    if (ld1) begin
      vld_pipe_d[1] = vld_pipe_q[0];
      if (vld_pipe_q[0]) begin
        r1_d = sum1;
        x1_d = x0_q;   // x travels with R1 so stage 2 can form t2
      end
    end
    if (ld2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) r2_d = sum2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
    end
  end

  assign in_ready  = ld0;
  assign out_valid = vld_pipe_q[2];
  assign y         = r2_q;
  assign busy      = |vld_pipe_q;
endmodule

// File: tb/tb_online_ccm_pipe.sv
// Bench for online_ccm_pipe: default C=44 plus NEG1 (C=28) and EN2=0 (C=40)
// instances sharing the same stimulus. Table of single-operand vectors,
// then back-to-back, stall/backpressure and mid-stall reset sequences.
module tb_online_ccm_pipe;
  localparam int YW = 22;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic [7:0] x;
  logic in_ready, out_valid, busy;
  logic in_ready_n, out_valid_n, busy_n;
  logic in_ready_e, out_valid_e, busy_e;
  logic [YW-1:0] y, y_n, y_e;

  always #5 clk = ~clk;

  online_ccm_pipe u_def (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy));
  online_ccm_pipe #(.NEG1(1'b1)) u_neg1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready_n), .x(x), .out_valid(out_valid_n), .out_ready(out_ready), .y(y_n),
    .busy(busy_n));
  online_ccm_pipe #(.EN2(1'b0)) u_en2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready_e), .x(x), .out_valid(out_valid_e), .out_ready(out_ready), .y(y_e),
    .busy(busy_e));

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_acc = 0, acc_cyc = 0;
  logic rdy_seen, busy_seen;
  int dq[$], dcyc[$], nq[$], eq[$];

  function automatic int sd_val(input logic [YW-1:0] v);
    int s = 0;
    for (int k = 0; k < YW/2; k++) s += (int'(v[2*k+1]) - int'(v[2*k])) * (1 << k);
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, observe 1ns later (well before posedge).
  task automatic cycle(input logic iv, input logic [7:0] xv, input logic ordy);
    @(negedge clk);
    in_valid = iv; x = xv; out_ready = ordy;
    #1;
    cyc++;
    rdy_seen  = in_ready;
    busy_seen = busy;
    if (in_valid && in_ready) begin n_acc++; acc_cyc = cyc; end
    if (out_valid && out_ready) begin dq.push_back(sd_val(y)); dcyc.push_back(cyc); end
    if (out_valid_n && out_ready) nq.push_back(sd_val(y_n));
    if (out_valid_e && out_ready) eq.push_back(sd_val(y_e));
  endtask

  task automatic clear_q();
    dq.delete(); dcyc.delete(); nq.delete(); eq.delete(); n_acc = 0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] xv;
    int         e_def;
    int         e_neg1;
    int         e_en2;
  } vec_t;
  vec_t tbl[6];

  int exp_seq[5];
  logic [7:0] xs[5];

  initial begin
    tbl[0] = '{"pos15",   8'b10101010,  660,  420,  600};
    tbl[1] = '{"neg15",   8'b01010101, -660, -420, -600};
    tbl[2] = '{"mixed7",  8'b10000110,  308,  196,  280};
    tbl[3] = '{"zero11",  8'b11111111,    0,    0,    0};
    tbl[4] = '{"one",     8'b00000010,   44,   28,   40};
    tbl[5] = '{"pad11_5", 8'b11101110,  220,  140,  200};
    exp_seq = '{44, 88, 132, 176, 220};
    xs      = '{8'b00000010, 8'b00001000, 8'b00001010, 8'b00100000, 8'b00100010};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy | busy_n | busy_e), 0);
    chk("rst_in_ready", int'(in_ready & in_ready_n & in_ready_e), 1);
    chk("rst_y_bits", int'(y == '0), 1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Single operands through an empty pipe, all three coefficients.
    foreach (tbl[i]) begin
      clear_q();
      cycle(1'b1, tbl[i].xv, 1'b1);
      chk({tbl[i].name, "_accept"}, n_acc, 1);
      for (int w = 0; w < 10 && dq.size() == 0; w++) cycle(1'b0, 8'h00, 1'b1);
      chk({tbl[i].name, "_got"}, dq.size(), 1);
      if (dq.size() > 0) begin
        chk({tbl[i].name, "_latency"}, dcyc[0] - acc_cyc, 3);
        chk({tbl[i].name, "_c44"}, dq[0], tbl[i].e_def);
      end
      if (nq.size() > 0) chk({tbl[i].name, "_c28"}, nq[0], tbl[i].e_neg1);
      else chk({tbl[i].name, "_c28_got"}, 0, 1);
      if (eq.size() > 0) chk({tbl[i].name, "_c40"}, eq[0], tbl[i].e_en2);
      else chk({tbl[i].name, "_c40_got"}, 0, 1);
    end

    // Back-to-back x=1..5 with out_ready held high.
    clear_q();
    for (int i = 0; i < 5; i++) cycle(1'b1, xs[i], 1'b1);
    chk("b2b_accepts", n_acc, 5);
    for (int w = 0; w < 12 && dq.size() < 5; w++) cycle(1'b0, 8'h00, 1'b1);
    chk("b2b_count", dq.size(), 5);
    if (dq.size() == 5) begin
      chk("b2b_consecutive", dcyc[4] - dcyc[0], 4);
      for (int i = 0; i < 5; i++) chk($sformatf("b2b_val%0d", i), dq[i], exp_seq[i]);
    end

    // Stall: out_ready low for 6 cycles, offer x in order.
    clear_q();
    for (int c = 0; c < 6; c++) cycle(1'b1, xs[n_acc < 5 ? n_acc : 4], 1'b0);
    chk("stall_accepts", n_acc, 3);
    chk("stall_in_ready", int'(rdy_seen), 0);
    chk("stall_busy", int'(busy_seen), 1);
    chk("stall_no_out", dq.size(), 0);
    for (int w = 0; w < 20 && n_acc < 5; w++) cycle(1'b1, xs[n_acc], 1'b1);
    chk("stall_all_accepted", n_acc, 5);
    for (int w = 0; w < 20 && dq.size() < 5; w++) cycle(1'b0, 8'h00, 1'b1);
    for (int w = 0; w < 4; w++) cycle(1'b0, 8'h00, 1'b1);
    chk("stall_count", dq.size(), 5);
    if (dq.size() == 5)
      for (int i = 0; i < 5; i++) chk($sformatf("stall_val%0d", i), dq[i], exp_seq[i]);

    // Reset while full and stalled; stale data must never appear.
    clear_q();
    for (int i = 0; i < 3; i++) cycle(1'b1, xs[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("full_busy", int'(busy_seen), 1);
    chk("full_out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk); #2 rst_n = 1'b1;
    clear_q();
    cycle(1'b1, xs[1], 1'b1);
    chk("postrst_in_ready", int'(rdy_seen), 1);
    for (int w = 0; w < 10 && dq.size() == 0; w++) cycle(1'b0, 8'h00, 1'b1);
    for (int w = 0; w < 4; w++) cycle(1'b0, 8'h00, 1'b1);
    chk("postrst_count", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("postrst_val", dq[0], 88);
      chk("postrst_latency", dcyc[0] - acc_cyc, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
